// File: rtl/wb_master_bridge.sv
// wb_master_bridge: Wishbone classic single-transfer initiator.
// Takes one read/write command over valid/ready, runs one bus cycle with a
// stb timeout, and returns read data or a timeout error over valid/ready.
module wb_master_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   // command channel
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   // response channel
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic [7:0]  err_count,
   // Wishbone initiator port
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   // Timer value seen on the edge that ends the TIMEOUT-th stb cycle.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic        cyc_q, cyc_d;
   logic        stb_q, stb_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
   logic [7:0]  err_count_q, err_count_d;

   assign cmd_ready = (state_q == IDLE) & ~wb_rst_i;

   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = wdat_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_dat   = rsp_dat_q;
   assign err_count = err_count_q;

   // Next-state and next-output logic; everything holds unless a state acts.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      wdat_d      = wdat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_dat_d   = rsp_dat_q;
      err_count_d = err_count_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = cmd_we;
               sel_d   = cmd_sel;
               adr_d   = cmd_adr;
               wdat_d  = cmd_we ? cmd_dat : 32'd0;
               timer_d = 16'd0;
               state_d = BUS;
            end
         end
         BUS: begin
            // Ack is checked first so a same-edge ack beats the timeout.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (timer_q == TMO_LAST) begin
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               we_d        = 1'b0;
               rsp_dat_d   = 32'd0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
               state_d     = RESP;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         RESP: begin
            // Late acks from the slave land here and are ignored.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         timer_q     <= 16'd0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= 4'd0;
         adr_q       <= 32'd0;
         wdat_q      <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= 32'd0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         wdat_q      <= wdat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed testbench for wb_master_bridge with TIMEOUT=8 and a registered-ack
// slave model whose ack latency is programmable.
module tb_wb_master_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_dat;
   logic [7:0]  err_count;
   logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
   logic [3:0]  wbm_sel;
   logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i;

   int tests = 0;
   int fails = 0;

   // slave model controls
   logic        slv_en;
   int          slv_wait;
   logic [31:0] slv_dat;
   int          slv_cnt;

   always #5 clk = ~clk;

   wb_master_bridge #(.TIMEOUT(8)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_err(rsp_err), .err_count(err_count),
      .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we),
      .wbm_sel_o(wbm_sel), .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack)
   );

   // Registered-ack slave: ack rises once stb has been seen for slv_wait+1
   // edges, and stays high one edge past stb falling (trailing ack).
   assign wbm_dat_i = slv_dat;
   always @(posedge clk) begin
      if (rst) begin
         slv_cnt <= 0;
         wbm_ack <= 1'b0;
      end else if (wbm_cyc && wbm_stb) begin
         slv_cnt <= slv_cnt + 1;
         wbm_ack <= slv_en && (slv_cnt >= slv_wait);
      end else begin
         slv_cnt <= 0;
         wbm_ack <= 1'b0;
      end
   end

   // Issue one command and follow it until rsp_valid (bounded).
   // stbc = stb-high cycles, lat = cycles from accept edge to rsp_valid.
   task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int stbc, output int lat,
                          output logic [31:0] c_adr, output logic [31:0] c_dat,
                          output logic [3:0] c_sel, output logic c_we);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      c_adr = wbm_adr; c_dat = wbm_dat_o; c_sel = wbm_sel; c_we = wbm_we;
      stbc = (wbm_cyc && wbm_stb) ? 1 : 0;
      lat = 0;
      while (!rsp_valid && lat < 400) begin
         @(posedge clk); #1; lat++;
         if (wbm_stb) stbc++;
      end
      $display("[TB] cmd we=%0b adr=%h dat=%h sel=%h -> stb=%0d lat=%0d rsp_dat=%h err=%0b cnt=%0d",
               we, adr, dat, sel, stbc, lat, rsp_dat, rsp_err, err_count);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready_in_rst got %b exp 0", cmd_ready); end
      tests++; if ({wbm_cyc, wbm_stb, wbm_we} !== 3'b000) begin fails++; $display("FAIL reset_ctrl got %b exp 000", {wbm_cyc, wbm_stb, wbm_we}); end
      tests++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp got %b%b exp 00", rsp_valid, rsp_err); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready_after got %b exp 1", cmd_ready); end
   endtask

   task automatic test_write();
      int stbc, lat; logic [31:0] a, d; logic [3:0] s; logic w;
      slv_en = 1'b1; slv_wait = 0; slv_dat = 32'hA5A5_5A5A;
      run_cmd(1'b1, 32'h3000_0004, 32'hDEADBEEF, 4'hF, stbc, lat, a, d, s, w);
      tests++; if (a !== 32'h3000_0004) begin fails++; $display("FAIL write_adr got %h exp 30000004", a); end
      tests++; if (d !== 32'hDEADBEEF) begin fails++; $display("FAIL write_dat got %h exp deadbeef", d); end
      tests++; if (s !== 4'hF || w !== 1'b1) begin fails++; $display("FAIL write_sel_we got %h/%b exp f/1", s, w); end
      tests++; if (stbc !== 2) begin fails++; $display("FAIL write_stb_cycles got %0d exp 2", stbc); end
      tests++; if (lat !== 2) begin fails++; $display("FAIL write_latency got %0d exp 2", lat); end
      tests++; if (rsp_err !== 1'b0 || rsp_dat !== 32'd0) begin fails++; $display("FAIL write_rsp got err=%b dat=%h exp 0/0", rsp_err, rsp_dat); end
      tests++; if ({wbm_cyc, wbm_stb, wbm_we} !== 3'b000) begin fails++; $display("FAIL write_bus_release got %b exp 000", {wbm_cyc, wbm_stb, wbm_we}); end
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL write_handshake got valid=%b ready=%b exp 0/1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_read_wait();
      int stbc, lat, extra; logic [31:0] a, d; logic [3:0] s; logic w;
      slv_en = 1'b1; slv_wait = 2; slv_dat = 32'h1234_5678;
      run_cmd(1'b0, 32'h3000_0010, 32'hFFFF_FFFF, 4'h3, stbc, lat, a, d, s, w);
      tests++; if (d !== 32'd0 || w !== 1'b0) begin fails++; $display("FAIL read_dat_o got %h we=%b exp 0/0", d, w); end
      tests++; if (stbc !== 4) begin fails++; $display("FAIL read_stb_cycles got %0d exp 4", stbc); end
      tests++; if (lat !== 4) begin fails++; $display("FAIL read_latency got %0d exp 4", lat); end
      tests++; if (rsp_dat !== 32'h1234_5678 || rsp_err !== 1'b0) begin fails++; $display("FAIL read_rsp got dat=%h err=%b exp 12345678/0", rsp_dat, rsp_err); end
      extra = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rsp_valid) extra++;
      end
      tests++; if (extra !== 0) begin fails++; $display("FAIL read_trailing_ack got %0d extra valid cycles exp 0", extra); end
   endtask

   task automatic test_timeout();
      int stbc, lat; logic [31:0] a, d; logic [3:0] s; logic w;
      slv_en = 1'b0;
      run_cmd(1'b0, 32'h3000_0020, 32'd0, 4'hF, stbc, lat, a, d, s, w);
      tests++; if (stbc !== 8) begin fails++; $display("FAIL timeout_stb_cycles got %0d exp 8", stbc); end
      tests++; if (rsp_err !== 1'b1 || rsp_dat !== 32'd0) begin fails++; $display("FAIL timeout_rsp got err=%b dat=%h exp 1/0", rsp_err, rsp_dat); end
      tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL timeout_err_count got %0d exp 1", err_count); end
      @(posedge clk); #1;
      tests++; if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL timeout_err_clear got err=%b valid=%b exp 0/0", rsp_err, rsp_valid); end
   endtask

   task automatic test_ack_at_timeout();
      int stbc, lat; logic [31:0] a, d; logic [3:0] s; logic w;
      slv_en = 1'b1; slv_wait = 6; slv_dat = 32'hCAFE_F00D;
      run_cmd(1'b0, 32'h3000_0030, 32'd0, 4'hF, stbc, lat, a, d, s, w);
      tests++; if (stbc !== 8) begin fails++; $display("FAIL ackto_stb_cycles got %0d exp 8", stbc); end
      tests++; if (rsp_err !== 1'b0 || rsp_dat !== 32'hCAFE_F00D) begin fails++; $display("FAIL ackto_rsp got err=%b dat=%h exp 0/cafef00d", rsp_err, rsp_dat); end
      tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL ackto_err_count got %0d exp 1", err_count); end
   endtask

   task automatic test_saturation();
      int stbc, lat; logic [31:0] a, d; logic [3:0] s; logic w;
      slv_en = 1'b0;
      for (int i = 2; i <= 300; i++) begin
         run_cmd(1'b0, 32'h3000_0040, 32'd0, 4'h1, stbc, lat, a, d, s, w);
         if (i == 254 || i == 255) begin
            tests++; if (err_count !== 8'(i)) begin fails++; $display("FAIL sat_count_%0d got %0d exp %0d", i, err_count, i); end
         end
      end
      tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL sat_final got %0d exp 255", err_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int stbc, lat, bad_hold, bad_ready, bad_bus; logic [31:0] a, d; logic [3:0] s; logic w;
      slv_en = 1'b1; slv_wait = 0; slv_dat = 32'h0BAD_F00D;
      rsp_ready = 1'b0;
      run_cmd(1'b0, 32'h3000_0050, 32'd0, 4'hF, stbc, lat, a, d, s, w);
      tests++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0BAD_F00D) begin fails++; $display("FAIL bp_first got valid=%b dat=%h exp 1/0badf00d", rsp_valid, rsp_dat); end
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0060; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF;
      bad_hold = 0; bad_ready = 0; bad_bus = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0BAD_F00D || rsp_err !== 1'b0) bad_hold++;
         if (cmd_ready !== 1'b0) bad_ready++;
         if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0) bad_bus++;
      end
      tests++; if (bad_hold !== 0) begin fails++; $display("FAIL bp_rsp_hold got %0d unstable cycles exp 0", bad_hold); end
      tests++; if (bad_ready !== 0) begin fails++; $display("FAIL bp_cmd_ready got %0d high cycles exp 0", bad_ready); end
      tests++; if (bad_bus !== 0) begin fails++; $display("FAIL bp_no_accept got %0d bus cycles exp 0", bad_bus); end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL bp_release got valid=%b ready=%b exp 0/1", rsp_valid, cmd_ready); end
      tests++; if (rsp_dat !== 32'h0BAD_F00D) begin fails++; $display("FAIL bp_dat_hold got %h exp 0badf00d", rsp_dat); end
   endtask

   task automatic test_reset_mid();
      int stbc, lat, seen; logic [31:0] a, d; logic [3:0] s; logic w;
      slv_en = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0070; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'hC;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (wbm_stb !== 1'b1) begin fails++; $display("FAIL rstmid_in_bus got stb=%b exp 1", wbm_stb); end
      rst = 1'b1;
      @(posedge clk); #1;
      tests++; if ({wbm_cyc, wbm_stb, wbm_we, rsp_valid} !== 4'b0000) begin fails++; $display("FAIL rstmid_ctrl got %b exp 0000", {wbm_cyc, wbm_stb, wbm_we, rsp_valid}); end
      tests++; if (wbm_adr !== 32'd0 || wbm_dat_o !== 32'd0 || wbm_sel !== 4'd0) begin fails++; $display("FAIL rstmid_bus got adr=%h dat=%h sel=%h exp 0", wbm_adr, wbm_dat_o, wbm_sel); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL rstmid_err_count got %0d exp 0", err_count); end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rstmid_cmd_ready got %b exp 1", cmd_ready); end
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (rsp_valid || wbm_cyc) seen++;
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL rstmid_no_rsp got %0d active cycles exp 0", seen); end
      slv_en = 1'b1; slv_wait = 0;
      run_cmd(1'b1, 32'h3000_0080, 32'h0123_4567, 4'h5, stbc, lat, a, d, s, w);
      tests++; if (lat !== 2 || rsp_err !== 1'b0 || d !== 32'h0123_4567 || s !== 4'h5) begin
         fails++; $display("FAIL rstmid_fresh got lat=%0d err=%b dat=%h sel=%h exp 2/0/01234567/5", lat, rsp_err, d, s);
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'd0; cmd_dat = 32'd0; cmd_sel = 4'd0;
      rsp_ready = 1'b1; slv_en = 1'b0; slv_wait = 0; slv_dat = 32'd0;
      #1;
      test_reset();
      test_write();
      test_read_wait();
      test_timeout();
      test_ack_at_timeout();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
